tcb_sub_mem: RTL and testbench



---
 rtl/tcb_sub_mem.sv | 132 +++++++++++++
 tb/tb_tcb_sub_mem.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/tcb_sub_mem.sv
`default_nettype none
// ============================================================================
// tcb_sub_mem : memory-backed TCB subordinate, fixed response delay, wait states
// Revision    : 1.0
// ============================================================================

module tcb_sub_mem #(
  parameter  int ABW  = 32,
  parameter  int DBW  = 32,
  parameter  int SLW  = 8,
  parameter  int DLY  = 1,
  parameter  int MEM  = 4096,
  parameter  int WAIT = 0,
  localparam int BEW  = DBW / SLW,
  localparam int SZW  = $clog2($clog2(BEW) + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tcb_vld,
  output logic           tcb_rdy,
  input  logic           tcb_wen,
  input  logic           tcb_ndn,
  input  logic [ABW-1:0] tcb_adr,
  input  logic [SZW-1:0] tcb_siz,
  input  logic [BEW-1:0] tcb_ben,
  input  logic [DBW-1:0] tcb_wdt,
  output logic [DBW-1:0] tcb_rdt,
  output logic           tcb_sts
);

  localparam int BSZ = $clog2(BEW);
  localparam int MAW = $clog2(MEM);
  localparam int DEP = MEM / BEW;

  logic [3:0]               cnt_q, cnt_d;
  logic                     w_trn, w_err, w_we;
  logic [ABW-1:0]           w_mask;
  logic [MAW-BSZ-1:0]       w_idx;
  logic [DBW-1:0]           w_rdt;
  logic [DLY-1:0]           w_ena;
  logic [DLY-1:0]           err_q;
  logic [DLY-1:0][DBW-1:0]  rdt_q;

  assign tcb_rdy = ~rst & (cnt_q == 4'(WAIT));
  assign w_trn   = tcb_vld & tcb_rdy;
  assign w_idx   = tcb_adr[MAW-1:BSZ];
  assign w_we    = w_trn & tcb_wen & ~w_err;

  always_comb begin
    w_mask = (ABW'(1) << tcb_siz) - ABW'(1);
    w_err  = (tcb_adr >= ABW'(MEM)) | (|(tcb_adr & w_mask)) | tcb_ndn
           | (tcb_siz > SZW'(BSZ));
  end

  // Counting continues only while a request is pending; an idle manager freezes it.
  always_comb begin
    cnt_d = cnt_q;
    if (w_trn) begin
      cnt_d = 4'd0;
    end else if (tcb_vld) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  generate
    for (genvar b = 0; b < BEW; b++) begin : g_lane
      logic [SLW-1:0] mem_q [DEP];

      always_ff @(posedge clk) begin
        if (w_we && tcb_ben[b]) begin
          mem_q[w_idx] <= tcb_wdt[b*SLW +: SLW];
        end
      end

      assign w_rdt[b*SLW +: SLW] = (tcb_ben[b] && !w_err) ? mem_q[w_idx] : '0;
    end
  endgenerate

  // Per-stage enables; w_ena[k] is the valid flag entering stage k.
  generate
    if (DLY > 1) begin : g_ena_pipe
      logic [DLY-2:0] ena_q;

      assign w_ena = {ena_q, w_trn};

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ena_q <= '0;
        end else begin
          ena_q <= w_ena[DLY-2:0];
        end
      end
    end else begin : g_ena_single
      assign w_ena = w_trn;
    end
  endgenerate

  // Data registers load only with a valid response, so the last stage holds on idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
      rdt_q <= '0;
    end else begin
      if (w_ena[0]) begin
        err_q[0] <= w_err;
        if (!tcb_wen) begin
          rdt_q[0] <= w_rdt;
        end
      end
      for (int k = 1; k < DLY; k++) begin
        if (w_ena[k]) begin
          err_q[k] <= err_q[k-1];
          rdt_q[k] <= rdt_q[k-1];
        end
      end
    end
  end

  assign tcb_rdt = rdt_q[DLY-1];
  assign tcb_sts = err_q[DLY-1];

endmodule

`default_nettype wire

// File: tb/tb_tcb_sub_mem.sv
`default_nettype none
// ============================================================================
// tb_tcb_sub_mem : directed self-checking bench for tcb_sub_mem
// Revision       : 1.0
// ============================================================================

module tb_tcb_sub_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld_a = 1'b0, vld_b = 1'b0, vld_c = 1'b0;
  logic        wen = 1'b0, ndn = 1'b0;
  logic [31:0] adr = '0, wdt = '0;
  logic [1:0]  siz = '0;
  logic [3:0]  ben = '0;

  logic        rdy_a, rdy_b, rdy_c;
  logic        sts_a, sts_b, sts_c;
  logic [31:0] rdt_a, rdt_b, rdt_c;

  int checks = 0;
  int errors = 0;

  logic [31:0] pdat [8] = '{32'h0101_A0A0, 32'h1234_5678, 32'h89AB_CDEF, 32'h0F0F_F0F0,
                            32'h5555_AAAA, 32'hC001_D00D, 32'h7E57_0042, 32'hFACE_B00C};

  always #5 clk = ~clk;

  tcb_sub_mem #(.DLY(1), .WAIT(0)) u_dut_a (
    .clk(clk), .rst(rst), .tcb_vld(vld_a), .tcb_rdy(rdy_a), .tcb_wen(wen), .tcb_ndn(ndn),
    .tcb_adr(adr), .tcb_siz(siz), .tcb_ben(ben), .tcb_wdt(wdt), .tcb_rdt(rdt_a), .tcb_sts(sts_a)
  );

  tcb_sub_mem #(.DLY(1), .WAIT(3)) u_dut_b (
    .clk(clk), .rst(rst), .tcb_vld(vld_b), .tcb_rdy(rdy_b), .tcb_wen(wen), .tcb_ndn(ndn),
    .tcb_adr(adr), .tcb_siz(siz), .tcb_ben(ben), .tcb_wdt(wdt), .tcb_rdt(rdt_b), .tcb_sts(sts_b)
  );

  tcb_sub_mem #(.DLY(3), .WAIT(0)) u_dut_c (
    .clk(clk), .rst(rst), .tcb_vld(vld_c), .tcb_rdy(rdy_c), .tcb_wen(wen), .tcb_ndn(ndn),
    .tcb_adr(adr), .tcb_siz(siz), .tcb_ben(ben), .tcb_wdt(wdt), .tcb_rdt(rdt_c), .tcb_sts(sts_c)
  );

  task automatic drive(input logic w, input logic [31:0] a, input logic [1:0] s,
                       input logic [3:0] be, input logic [31:0] d, input logic n);
    wen = w; adr = a; siz = s; ben = be; wdt = d; ndn = n;
  endtask

  // One transfer on the DLY=1, WAIT=0 instance; returns just after the trn edge.
  task automatic xfer_a(input logic w, input logic [31:0] a, input logic [1:0] s,
                        input logic [3:0] be, input logic [31:0] d, input logic n);
    @(negedge clk);
    drive(w, a, s, be, d, n);
    vld_a = 1'b1;
    @(posedge clk);
    #1;
    vld_a = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL rst_rdy: got %b expected 0", rdy_a); end
    checks++; if (rdt_a !== 32'h0) begin errors++; $display("FAIL rst_rdt: got %h expected 0", rdt_a); end
    checks++; if (sts_a !== 1'b0) begin errors++; $display("FAIL rst_sts: got %b expected 0", sts_a); end
    checks++; if (rdy_c !== 1'b0) begin errors++; $display("FAIL rst_rdy_c: got %b expected 0", rdy_c); end
    rst = 1'b0;
    #1;
    checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL post_rst_rdy: got %b expected 1", rdy_a); end
    checks++; if (rdy_b !== 1'b0) begin errors++; $display("FAIL post_rst_rdy_wait: got %b expected 0", rdy_b); end
  endtask

  task automatic test_word;
    xfer_a(1'b1, 32'h10, 2'd2, 4'hF, 32'hDEADBEEF, 1'b0);
    checks++; if (sts_a !== 1'b0) begin errors++; $display("FAIL word_wr_sts: got %b expected 0", sts_a); end
    xfer_a(1'b0, 32'h10, 2'd2, 4'hF, 32'h0, 1'b0);
    checks++; if (rdt_a !== 32'hDEADBEEF) begin errors++; $display("FAIL word_rd: got %h expected deadbeef", rdt_a); end
    checks++; if (sts_a !== 1'b0) begin errors++; $display("FAIL word_rd_sts: got %b expected 0", sts_a); end
    @(negedge clk);
    checks++; if (rdt_a !== 32'hDEADBEEF) begin errors++; $display("FAIL word_hold: got %h expected deadbeef", rdt_a); end
  endtask

  task automatic test_lanes;
    xfer_a(1'b1, 32'h20, 2'd2, 4'hF, 32'h11223344, 1'b0);
    xfer_a(1'b1, 32'h22, 2'd0, 4'b0100, 32'h00AA0000, 1'b0);
    xfer_a(1'b0, 32'h20, 2'd2, 4'hF, 32'h0, 1'b0);
    checks++; if (rdt_a !== 32'h11AA3344) begin errors++; $display("FAIL lane_rd: got %h expected 11aa3344", rdt_a); end
    xfer_a(1'b0, 32'h20, 2'd1, 4'b0011, 32'h0, 1'b0);
    checks++; if (rdt_a !== 32'h00003344) begin errors++; $display("FAIL lane_rd_half: got %h expected 00003344", rdt_a); end
  endtask

  task automatic test_errors;
    xfer_a(1'b0, 32'h1000, 2'd2, 4'hF, 32'h0, 1'b0);
    checks++; if (sts_a !== 1'b1) begin errors++; $display("FAIL err_oob_sts: got %b expected 1", sts_a); end
    checks++; if (rdt_a !== 32'h0) begin errors++; $display("FAIL err_oob_rdt: got %h expected 0", rdt_a); end
    xfer_a(1'b1, 32'h21, 2'd2, 4'hF, 32'hFFFFFFFF, 1'b0);
    checks++; if (sts_a !== 1'b1) begin errors++; $display("FAIL err_align_sts: got %b expected 1", sts_a); end
    xfer_a(1'b0, 32'h20, 2'd2, 4'hF, 32'h0, 1'b0);
    checks++; if (rdt_a !== 32'h11AA3344) begin errors++; $display("FAIL err_align_mem: got %h expected 11aa3344", rdt_a); end
    checks++; if (sts_a !== 1'b0) begin errors++; $display("FAIL err_clear_sts: got %b expected 0", sts_a); end
    xfer_a(1'b0, 32'h20, 2'd2, 4'hF, 32'h0, 1'b1);
    checks++; if (sts_a !== 1'b1) begin errors++; $display("FAIL err_ndn_sts: got %b expected 1", sts_a); end
    checks++; if (rdt_a !== 32'h0) begin errors++; $display("FAIL err_ndn_rdt: got %h expected 0", rdt_a); end
    xfer_a(1'b0, 32'h20, 2'd3, 4'hF, 32'h0, 1'b0);
    checks++; if (sts_a !== 1'b1) begin errors++; $display("FAIL err_siz_sts: got %b expected 1", sts_a); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    drive(1'b1, 32'h30, 2'd2, 4'hF, 32'hCAFEF00D, 1'b0);
    vld_a = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b0, 32'h30, 2'd2, 4'hF, 32'h0, 1'b0);
    checks++; if (sts_a !== 1'b0) begin errors++; $display("FAIL b2b_wr_sts: got %b expected 0", sts_a); end
    @(posedge clk);
    #1;
    vld_a = 1'b0;
    checks++; if (rdt_a !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_raw: got %h expected cafef00d", rdt_a); end
  endtask

  task automatic test_wait;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      case ((n - 1) / 4)
        0:       drive(1'b1, 32'h40, 2'd2, 4'hF, 32'h01020304, 1'b0);
        1:       drive(1'b1, 32'h44, 2'd2, 4'hF, 32'hA5A5A5A5, 1'b0);
        default: drive(1'b0, 32'h40, 2'd2, 4'hF, 32'h0, 1'b0);
      endcase
      vld_b = 1'b1;
      #1;
      checks++;
      if (rdy_b !== ((n % 4) == 0)) begin
        errors++; $display("FAIL wait_rdy cycle %0d: got %b expected %b", n, rdy_b, (n % 4) == 0);
      end
    end
    @(negedge clk);
    vld_b = 1'b0;
    #1;
    checks++; if (rdt_b !== 32'h01020304) begin errors++; $display("FAIL wait_rd: got %h expected 01020304", rdt_b); end
    checks++; if (sts_b !== 1'b0) begin errors++; $display("FAIL wait_sts: got %b expected 0", sts_b); end
  endtask

  task automatic test_pipeline;
    logic [31:0] exp;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(1'b1, 32'h100 + 32'(4 * i), 2'd2, 4'hF, pdat[i], 1'b0);
      vld_c = 1'b1;
    end
    @(negedge clk);
    vld_c = 1'b0;
    repeat (4) @(negedge clk);
    for (int j = 0; j < 14; j++) begin
      @(negedge clk);
      if (j < 8) begin
        drive(1'b0, 32'h100 + 32'(4 * j), 2'd2, 4'hF, 32'h0, 1'b0);
        vld_c = 1'b1;
      end else begin
        vld_c = 1'b0;
      end
      #1;
      exp = (j < 3) ? 32'h0 : pdat[(j - 3 > 7) ? 7 : j - 3];
      checks++;
      if (rdt_c !== exp) begin
        errors++; $display("FAIL pipe_rdt cycle %0d: got %h expected %h", j, rdt_c, exp);
      end
    end
    checks++; if (sts_c !== 1'b0) begin errors++; $display("FAIL pipe_sts: got %b expected 0", sts_c); end
  endtask

  task automatic test_reset_midflight;
    @(negedge clk);
    drive(1'b0, 32'h100, 2'd2, 4'hF, 32'h0, 1'b0);
    vld_c = 1'b1;
    @(negedge clk);
    drive(1'b0, 32'h104, 2'd2, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    vld_c = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (rdt_c !== 32'h0) begin errors++; $display("FAIL mid_rst_rdt: got %h expected 0", rdt_c); end
    checks++; if (sts_c !== 1'b0) begin errors++; $display("FAIL mid_rst_sts: got %b expected 0", sts_c); end
    checks++; if (rdy_c !== 1'b0) begin errors++; $display("FAIL mid_rst_rdy: got %b expected 0", rdy_c); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (rdy_c !== 1'b1) begin errors++; $display("FAIL mid_rel_rdy: got %b expected 1", rdy_c); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (rdt_c !== 32'h0) begin errors++; $display("FAIL mid_flush cycle %0d: got %h expected 0", k, rdt_c); end
    end
    @(negedge clk);
    drive(1'b0, 32'h11C, 2'd2, 4'hF, 32'h0, 1'b0);
    vld_c = 1'b1;
    @(negedge clk);
    vld_c = 1'b0;
    @(negedge clk);
    checks++; if (rdt_c !== 32'h0) begin errors++; $display("FAIL resume_early: got %h expected 0", rdt_c); end
    @(negedge clk);
    checks++; if (rdt_c !== pdat[7]) begin errors++; $display("FAIL resume_rd: got %h expected %h", rdt_c, pdat[7]); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_lanes();
    test_errors();
    test_back_to_back();
    test_wait();
    test_pipeline();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
